// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access encoding, error/transaction-type enums and the error record layout.
package rv_iopmp_pkg;

    localparam int REC_SID_WIDTH  = 8;
    localparam int REC_ADDR_WIDTH = 64;
    localparam int REC_EID_WIDTH  = 16;

    typedef enum logic [2:0] {
        ACCESS_NONE      = 3'b000,
        ACCESS_READ      = 3'b001,
        ACCESS_WRITE     = 3'b010,
        ACCESS_EXECUTION = 3'b100
    } access_t;

    typedef enum logic [2:0] {
        ERR_READ        = 3'd1,
        ERR_WRITE       = 3'd2,
        ERR_EXEC        = 3'd3,
        ERR_NO_HIT      = 3'd5,
        ERR_UNKNOWN_SID = 3'd6,
        ERR_OTHER       = 3'd7
    } err_type_e;

    typedef enum logic [1:0] {
        TTYPE_NONE  = 2'd0,
        TTYPE_READ  = 2'd1,
        TTYPE_WRITE = 2'd2,
        TTYPE_EXEC  = 2'd3
    } ttype_e;

    typedef struct packed {
        ttype_e                     ttype;
        err_type_e                  etype;
        logic [REC_EID_WIDTH-1:0]   eid;
        logic [REC_SID_WIDTH-1:0]   sid;
        logic [REC_ADDR_WIDTH-1:0]  addr;
    } err_record_t;

    function automatic ttype_e access_to_ttype(input access_t acc);
        case (acc)
            ACCESS_READ:      return TTYPE_READ;
            ACCESS_WRITE:     return TTYPE_WRITE;
            ACCESS_EXECUTION: return TTYPE_EXEC;
            default:          return TTYPE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error-record stage: holds the first violation until cleared, raises irq, requests bus errors.
// Optional saturating overflow counter enabled by RV_IOPMP_ERR_OVF_CNT_EN.
module rv_iopmp_err_capture
    import rv_iopmp_pkg::*;
#(
    parameter int SID_WIDTH       = 8,
    parameter int ADDR_WIDTH      = 64,
    parameter int ENTRY_IDX_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       txn_valid_i,
    input  logic                       err_transaction_i,
    input  logic [2:0]                 err_type_i,
    input  logic [ENTRY_IDX_WIDTH-1:0] err_entry_index_i,
    input  logic [SID_WIDTH-1:0]       sid_i,
    input  logic [ADDR_WIDTH-1:0]      addr_i,
    input  logic [2:0]                 access_type_i,
    input  logic                       cfg_ie_i,
    input  logic                       cfg_rs_i,
    input  logic                       clr_i,
    output logic                       rec_valid_o,
    output logic [1:0]                 rec_ttype_o,
    output logic [2:0]                 rec_etype_o,
    output logic [ENTRY_IDX_WIDTH-1:0] rec_eid_o,
    output logic [SID_WIDTH-1:0]       rec_sid_o,
    output logic [ADDR_WIDTH-1:0]      rec_addr_o,
    output logic                       irq_o,
`ifdef RV_IOPMP_ERR_OVF_CNT_EN
    output logic [7:0]                 ovf_cnt_o,
`endif
    output logic                       bus_err_o
);

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_e;

    state_e      state_q, state_d;
    err_record_t rec_q, rec_d, new_rec;
    logic        bus_err_q;
    logic        ev;

    assign ev = txn_valid_i & err_transaction_i;

    always_comb begin
        new_rec       = '0;
        new_rec.ttype = access_to_ttype(access_t'(access_type_i));
        new_rec.etype = err_type_e'(err_type_i);
        new_rec.eid   = REC_EID_WIDTH'(err_entry_index_i);
        new_rec.sid   = REC_SID_WIDTH'(sid_i);
        new_rec.addr  = REC_ADDR_WIDTH'(addr_i);
    end

    // A clear coinciding with a new violation re-arms with the new error rather than dropping it.
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        case (state_q)
            IDLE: begin
                if (ev) begin
                    rec_d   = new_rec;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (clr_i && ev) begin
                    rec_d = new_rec;
                end else if (clr_i) begin
                    rec_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rec_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rec_q     <= rec_d;
            bus_err_q <= ev & ~cfg_rs_i;
        end
    end

    assign rec_valid_o = (state_q == HELD);
    assign rec_ttype_o = rec_q.ttype;
    assign rec_etype_o = rec_q.etype;
    assign rec_eid_o   = ENTRY_IDX_WIDTH'(rec_q.eid);
    assign rec_sid_o   = SID_WIDTH'(rec_q.sid);
    assign rec_addr_o  = ADDR_WIDTH'(rec_q.addr);
    assign irq_o       = rec_valid_o & cfg_ie_i;
    assign bus_err_o   = bus_err_q;

`ifdef RV_IOPMP_ERR_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Only violations that could not be recorded count; a clear+ev pair records the ev instead.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clr_i) begin
            ovf_cnt_d = '0;
        end else if ((state_q == HELD) && ev && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rv_iopmp_err_capture.sv
// Scoreboard bench for rv_iopmp_err_capture; covers ovf_cnt_o when RV_IOPMP_ERR_OVF_CNT_EN is defined.
module tb_rv_iopmp_err_capture;
    import rv_iopmp_pkg::*;

`ifdef RV_IOPMP_ERR_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        txn_valid, err_transaction, cfg_ie, cfg_rs, clr;
    logic [2:0]  err_type, access_type;
    logic [15:0] eid;
    logic [7:0]  sid;
    logic [63:0] addr;
    logic        rec_valid, irq, bus_err;
    logic [1:0]  rec_ttype;
    logic [2:0]  rec_etype;
    logic [15:0] rec_eid;
    logic [7:0]  rec_sid;
    logic [63:0] rec_addr;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        valid;
        logic [1:0]  ttype;
        logic [2:0]  etype;
        logic [15:0] eid;
        logic [7:0]  sid;
        logic [63:0] addr;
        logic        irq;
        logic        bus_err;
        logic [7:0]  ovf;
    } obs_t;

    obs_t exp_q[$];
    obs_t got, want;

    always #5 clk = ~clk;

    rv_iopmp_err_capture #(
        .SID_WIDTH(8), .ADDR_WIDTH(64), .ENTRY_IDX_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .txn_valid_i(txn_valid), .err_transaction_i(err_transaction),
        .err_type_i(err_type), .err_entry_index_i(eid),
        .sid_i(sid), .addr_i(addr), .access_type_i(access_type),
        .cfg_ie_i(cfg_ie), .cfg_rs_i(cfg_rs), .clr_i(clr),
        .rec_valid_o(rec_valid), .rec_ttype_o(rec_ttype), .rec_etype_o(rec_etype),
        .rec_eid_o(rec_eid), .rec_sid_o(rec_sid), .rec_addr_o(rec_addr),
        .irq_o(irq),
`ifdef RV_IOPMP_ERR_OVF_CNT_EN
        .ovf_cnt_o(ovf_cnt),
`endif
        .bus_err_o(bus_err)
    );

`ifndef RV_IOPMP_ERR_OVF_CNT_EN
    assign ovf_cnt = 8'h00;
`endif

    function automatic obs_t sample();
        obs_t o;
        o.valid = rec_valid;  o.ttype = rec_ttype; o.etype = rec_etype;
        o.eid = rec_eid;      o.sid = rec_sid;     o.addr = rec_addr;
        o.irq = irq;          o.bus_err = bus_err;
        o.ovf = OVF_EN ? ovf_cnt : 8'h00;
        return o;
    endfunction

    function automatic obs_t mk(input logic v, input logic [1:0] tt, input logic [2:0] et,
                                input logic [15:0] e, input logic [7:0] s, input logic [63:0] a,
                                input logic i, input logic b, input int unsigned ov);
        obs_t o;
        o.valid = v; o.ttype = tt; o.etype = et; o.eid = e; o.sid = s; o.addr = a;
        o.irq = i; o.bus_err = b;
        o.ovf = OVF_EN ? ov[7:0] : 8'h00;
        return o;
    endfunction

    task automatic drive(input logic v, input logic e, input logic [2:0] et, input logic [15:0] ei,
                         input logic [7:0] s, input logic [63:0] a, input logic [2:0] acc,
                         input logic c);
        txn_valid = v; err_transaction = e; err_type = et; eid = ei;
        sid = s; addr = a; access_type = acc; clr = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 16'd0, 8'd0, 64'd0, 3'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] ADDR_A = 64'h0000_0000_8000_1000;
    localparam logic [63:0] ADDR_C = 64'h0000_0000_0000_2000;
    localparam logic [63:0] ADDR_D = 64'hDEAD_BEEF_0000_0040;

    task automatic test_reset();
        rst = 1'b1; idle(); cfg_ie = 1'b1; cfg_rs = 1'b0;
        tick(); tick();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset got=%h want=%h", got, want); end
        else $display("check reset ok");
        rst = 1'b0;
    endtask

    task automatic test_capture();
        drive(1, 1, 3'd5, 16'd0, 8'd1, ADDR_A, ACCESS_READ, 0);
        exp_q.push_back(mk(1, 2'd1, 3'd5, 0, 8'd1, ADDR_A, 1, 1, 0));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL capture_a got=%h want=%h", got, want); end
        else $display("check capture_a ok");
        idle();
        exp_q.push_back(mk(1, 2'd1, 3'd5, 0, 8'd1, ADDR_A, 1, 0, 0));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL capture_a_hold got=%h want=%h", got, want); end
        else $display("check capture_a_hold ok");
        cfg_ie = 1'b0;
        exp_q.push_back(mk(1, 2'd1, 3'd5, 0, 8'd1, ADDR_A, 0, 0, 0));
        #1; got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL irq_disable got=%h want=%h", got, want); end
        else $display("check irq_disable ok");
        cfg_ie = 1'b1;
    endtask

    task automatic test_overflow();
        drive(1, 1, 3'd2, 16'd7, 8'd2, 64'h1000, ACCESS_WRITE, 0);
        exp_q.push_back(mk(1, 2'd1, 3'd5, 0, 8'd1, ADDR_A, 1, 1, 1));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL overflow_b got=%h want=%h", got, want); end
        else $display("check overflow_b ok");
    endtask

    task automatic test_clr_with_ev();
        drive(1, 1, 3'd3, 16'd4, 8'd3, ADDR_C, ACCESS_EXECUTION, 1);
        exp_q.push_back(mk(1, 2'd3, 3'd3, 16'd4, 8'd3, ADDR_C, 1, 1, 0));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL clr_ev_c got=%h want=%h", got, want); end
        else $display("check clr_ev_c ok");
    endtask

    task automatic test_clr();
        drive(0, 0, 3'd0, 16'd0, 8'd0, 64'd0, 3'd0, 1);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            tick(); got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL clr_%0d got=%h want=%h", i, got, want); end
            else $display("check clr_%0d ok", i);
        end
        idle();
    endtask

    task automatic test_ignored();
        drive(0, 1, 3'd7, 16'd3, 8'd9, 64'h40, ACCESS_READ, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL no_valid got=%h want=%h", got, want); end
        else $display("check no_valid ok");
        drive(1, 0, 3'd7, 16'd3, 8'd9, 64'h40, ACCESS_READ, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL no_err got=%h want=%h", got, want); end
        else $display("check no_err ok");
    endtask

    task automatic test_rs();
        cfg_rs = 1'b1;
        drive(1, 1, 3'd6, 16'd9, 8'hAA, ADDR_D, ACCESS_WRITE, 0);
        exp_q.push_back(mk(1, 2'd2, 3'd6, 16'd9, 8'hAA, ADDR_D, 1, 0, 0));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL rs_capture got=%h want=%h", got, want); end
        else $display("check rs_capture ok");
        cfg_rs = 1'b0; idle();
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 3'd1, 16'd1, 8'd5, 64'h10, ACCESS_READ, 0);
        exp_q.push_back(mk(1, 2'd2, 3'd6, 16'd9, 8'hAA, ADDR_D, 1, 1, 1));
        exp_q.push_back(mk(1, 2'd2, 3'd6, 16'd9, 8'hAA, ADDR_D, 1, 1, 2));
        for (int i = 0; i < 2; i++) begin
            tick(); got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL b2b_%0d got=%h want=%h", i, got, want); end
            else $display("check b2b_%0d ok", i);
        end
        idle();
        exp_q.push_back(mk(1, 2'd2, 3'd6, 16'd9, 8'hAA, ADDR_D, 1, 0, 2));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL b2b_drop got=%h want=%h", got, want); end
        else $display("check b2b_drop ok");
    endtask

    task automatic test_saturate();
        int unsigned cnt = 2;
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 3'd7, 16'(i), 8'(i), 64'(i), ACCESS_WRITE, 0);
            cnt = (cnt < 255) ? cnt + 1 : 255;
            exp_q.push_back(mk(1, 2'd2, 3'd6, 16'd9, 8'hAA, ADDR_D, 1, 1, cnt));
            tick(); got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin failures++; $display("FAIL sat_%0d got=%h want=%h", i, got, want); end
            else $display("check sat_%0d ok ovf=%0d", i, got.ovf);
        end
    endtask

    task automatic test_reset_mid_held();
        rst = 1'b1;
        drive(1, 1, 3'd5, 16'd2, 8'd4, 64'h3000, ACCESS_READ, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL rst_held got=%h want=%h", got, want); end
        else $display("check rst_held ok");
        rst = 1'b0; idle();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick(); got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL rst_after got=%h want=%h", got, want); end
        else $display("check rst_after ok");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture();
        test_overflow();
        test_clr_with_ev();
        test_clr();
        test_ignored();
        test_rs();
        test_back_to_back();
        test_saturate();
        test_reset_mid_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_iopmp_err_capture.md
Name: rv_iopmp_err_capture

Overview:
- Error-record stage directly downstream of the IOPMP decision logic.
- Latches the first violating transaction (type, entry index, SID, address, access) into the ERR_REQINFO/ERR_REQID/ERR_REQADDR record.
- Holds that record until software clears it; raises the IOPMP interrupt.
- Signals a bus-error response to the master on every violation, whether or not it was recorded.

Parameters:
- SID_WIDTH, 8, width of source ID.
- ADDR_WIDTH, 64, width of transaction address.
- ENTRY_IDX_WIDTH, 16, width of recorded entry index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- txn_valid_i  in  1  checked transaction present this cycle (DL outputs valid).
- err_transaction_i  in  1  DL error flag.
- err_type_i  in  3  DL error type.
- err_entry_index_i  in  ENTRY_IDX_WIDTH  DL entry index.
- sid_i  in  SID_WIDTH  transaction SID.
- addr_i  in  ADDR_WIDTH  transaction address.
- access_type_i  in  3  rv_iopmp_pkg::access_t of transaction.
- cfg_ie_i  in  1  ERR_CFG.ie, interrupt enable.
- cfg_rs_i  in  1  ERR_CFG.rs, suppress bus-error response.
- clr_i  in  1  one-cycle pulse: software wrote 1 to ERR_REQINFO.v.
- rec_valid_o  out  1  ERR_REQINFO.v.
- rec_ttype_o  out  2  recorded transaction type (ERR_REQINFO.ttype).
- rec_etype_o  out  3  recorded error type.
- rec_eid_o  out  ENTRY_IDX_WIDTH  recorded entry index.
- rec_sid_o  out  SID_WIDTH  recorded SID.
- rec_addr_o  out  ADDR_WIDTH  recorded address.
- irq_o  out  1  interrupt.
- bus_err_o  out  1  registered error-response request to the master port.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Error event: ev = txn_valid_i & err_transaction_i.
- Two states, driven by rec_valid_o:
  - IDLE: on ev, capture all fields next cycle (1-cycle latency) and go to HELD.
  - HELD: fields frozen; further ev does not overwrite.
  - HELD with clr_i and no ev → IDLE, all rec_* fields zeroed.
  - HELD with clr_i and ev in the same cycle → capture the new error and stay HELD. The new error wins and is not lost.
  - IDLE with clr_i → ignored.
- rec_ttype_o mapping from access_type_i: READ→1, WRITE→2, EXECUTION→3, other→0.
- irq_o = rec_valid_o & cfg_ie_i, combinational from registers.
  - cfg_ie_i toggling while HELD changes irq_o immediately.
  - The record is unaffected by cfg_ie_i.
- bus_err_o:
  - Registered: bus_err_o = ev & ~cfg_rs_i from the previous cycle.
  - Asserted for every violation, in both IDLE and HELD.
  - Deasserted in the next cycle unless another ev occurs.
- err_transaction_i with txn_valid_i=0 → ignored.
- Reset asserted mid-HELD → IDLE next edge; pending ev in that cycle dropped.

Optional Feature:
- Macro: RV_IOPMP_ERR_OVF_CNT_EN.
- With it defined:
  - Extra output ovf_cnt_o[7:0].
  - Counts ev occurring while HELD and not coinciding with clr_i.
  - Saturates at 255.
  - Cleared to 0 on clr_i and on reset.
- Without it: port absent; overflow errors silently dropped from the record (bus_err_o unchanged).

Decomposition:
- Shared package rv_iopmp_pkg:
  - access_t.
  - New err_type_e enum: READ=1, WRITE=2, EXEC=3, NO_HIT=5, UNKNOWN_SID=6, OTHER=7.
  - New ttype_e enum.
  - err_record_t packed struct (ttype, etype, eid, sid, addr).
- Single flat module; no sub-module warranted.
- The optional counter is an inline generate-free `ifdef block.

Test Plan:
- Reset then ev with type 5, eid 0, sid 1, addr 0x8000_1000, READ → next cycle:
  - rec_valid_o=1, rec_etype_o=5, rec_ttype_o=1, rec_sid_o=1, rec_addr_o=0x8000_1000.
  - bus_err_o=1 for one cycle.
  - irq_o=1 when cfg_ie_i=1.
- HELD with record A, then ev B (type 2, addr 0x1000):
  - Record still A; bus_err_o=1.
  - With RV_IOPMP_ERR_OVF_CNT_EN, ovf_cnt_o=1.
- HELD, clr_i and ev C (type 3, eid 4) same cycle → rec_valid_o stays 1; record = C, rec_ttype_o=3, rec_eid_o=4; ovf_cnt_o=0.
- HELD, clr_i alone → rec_valid_o=0, irq_o=0, fields 0; a second clr_i in IDLE has no effect.
- cfg_rs_i=1, ev → record captured and irq_o=1, but bus_err_o stays 0.
- 300 ev while HELD with counter enabled → ovf_cnt_o saturates at 255.
- Reset asserted mid-HELD with a coincident ev → all outputs 0 next cycle.
